alu_share_arbiter: RTL

- Shares one combinational ALU between NUM_REQ requesters, e.g. a main-datapath port plus an address/branch-compare port.
- Round-robin arbitration, valid/ready request handshake, registered operands, and a single registered response bus tagged with the requester ID.
- Sits between the requesters and the ALU. The ALU consumes the 4-bit ALUControl encoding: ADD=0000, SUB=0001, XOR=0010, OR=0011, AND=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001.

---
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU among NUM_REQ requesters.
// Define ALU_ARB_STATS_EN to add per-requester saturating grant counters (clr_stats, grant_cnt).
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]    req_ctrl,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [3:0]              alu_ctrl,
    input  logic [DATA_W-1:0]       alu_result,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [1:0]              resp_id,
    output logic [DATA_W-1:0]       resp_data
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic                    clr_stats,
    output logic [NUM_REQ*16-1:0]   grant_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] rr_ptr;
    logic [1:0] owner;
    logic [1:0] grant_idx;
    logic       grant_found;
    logic       accept;

    // Scan from rr_ptr upward so the previous winner is considered last.
    always_comb begin
        int j;
        j           = 0;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = 2'(j);
            end
        end
    end

    assign accept = (state == IDLE) && grant_found;

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = accept && (int'(grant_idx) == k);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 2'd0;
            owner      <= 2'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= 4'b0000;
            resp_valid <= 1'b0;
            resp_id    <= 2'd0;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a    <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
                        alu_b    <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
                        alu_ctrl <= req_ctrl[int'(grant_idx)*4 +: 4];
                        owner    <= grant_idx;
                    end
                end
                EXEC: begin
                    resp_data  <= alu_result;
                    resp_id    <= owner;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (int'(owner) == NUM_REQ - 1) rr_ptr <= 2'd0;
                        else                            rr_ptr <= owner + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    // Clear wins over a same-cycle accept; counters stick at all-ones.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rst || clr_stats) begin
                cnt[k] <= 16'd0;
            end else if (accept && (int'(grant_idx) == k) && (cnt[k] != 16'hFFFF)) begin
                cnt[k] <= cnt[k] + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_cnt[k*16 +: 16] = cnt[k];
        end
    end
`endif

endmodule
